// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - operand forwarding and hazard stall control for a 5-stage RV32I pipeline
//
// Purpose: selects ALU and ID-comparator operand forwarding sources and runs
// a two-state (RUN/HOLD) stall machine that inserts load-use and
// branch-compare bubbles. Only the FSM state and the optional statistics
// counters are registered; everything else is combinational.
//
// Optional feature macro: HAZ_STATS_EN adds the stall_cycles and
// hazard_events saturating counters.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   id_opcode              opcode of the instruction in IF/ID
//   id_rs1, id_rs2         IF/ID source registers
//   ex_rs1, ex_rs2         ID/EX source registers
//   ex_rd/ex_reg_wr/ex_mem_rd     ID/EX destination, write enable, load flag
//   mem_rd/mem_reg_wr/mem_mem_rd  EX/MEM destination, write enable, load flag
//   wb_rd/wb_reg_wr        MEM/WB destination and write enable
//   br_flush               taken-branch/jump redirect
//   fw_a, fw_b             ALU operand selects (00 RF, 01 EX/MEM, 10 MEM/WB)
//   fw_p, fw_q             ID comparator selects, same encoding
//   stall                  hold PC and IF/ID
//   flush_ex               inject a bubble into ID/EX
//   stall_cycles           (HAZ_STATS_EN) cycles with stall asserted
//   hazard_events          (HAZ_STATS_EN) number of stall entries from RUN
module fwd_hazard_ctrl #(
   parameter int REG_AW   = 5,
   parameter bit BR_IN_ID = 1'b1,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [6:0]        id_opcode,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] ex_rs1,
   input  logic [REG_AW-1:0] ex_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_reg_wr,
   input  logic              ex_mem_rd,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_reg_wr,
   input  logic              mem_mem_rd,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_reg_wr,
   input  logic              br_flush,
   output logic [1:0]        fw_a,
   output logic [1:0]        fw_b,
   output logic [1:0]        fw_p,
   output logic [1:0]        fw_q,
   output logic              stall,
   output logic              flush_ex
`ifdef HAZ_STATS_EN
   ,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  hazard_events
`endif
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic {
      S_RUN  = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic       rs1_used, rs2_used, is_branch, br_mode;
   logic       ex_hit, mem_hit;
   logic [1:0] hazard_n;
   logic       stall_raw;
   logic [1:0] fw_a_raw, fw_b_raw, fw_p_raw, fw_q_raw;

   // A producer matches when it writes a non-zero rd equal to the source.
   function automatic logic prod_match(input logic wr,
                                       input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] r);
      return wr && (rd != '0) && (rd == r);
   endfunction

   // EX/MEM is the younger result, so it wins over MEM/WB.
   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] r,
                                          input logic m_wr,
                                          input logic [REG_AW-1:0] m_rd,
                                          input logic w_wr,
                                          input logic [REG_AW-1:0] w_rd);
      if (prod_match(m_wr, m_rd, r)) return 2'b01;
      else if (prod_match(w_wr, w_rd, r)) return 2'b10;
      else return 2'b00;
   endfunction

   assign rs1_used  = !((id_opcode == OP_LUI) || (id_opcode == OP_AUIPC) ||
                        (id_opcode == OP_JAL));
   assign rs2_used  = (id_opcode == OP_REG) || (id_opcode == OP_STORE) ||
                      (id_opcode == OP_BRANCH);
   assign is_branch = (id_opcode == OP_BRANCH);
   // With EX-stage branch resolution a branch is just another rs1/rs2 consumer.
   assign br_mode   = BR_IN_ID && is_branch;

   assign ex_hit  = (rs1_used && prod_match(ex_reg_wr, ex_rd, id_rs1)) ||
                    (rs2_used && prod_match(ex_reg_wr, ex_rd, id_rs2));
   assign mem_hit = (rs1_used && prod_match(mem_reg_wr, mem_rd, id_rs1)) ||
                    (rs2_used && prod_match(mem_reg_wr, mem_rd, id_rs2));

   assign fw_a_raw = fwd_sel(ex_rs1, mem_reg_wr, mem_rd, wb_reg_wr, wb_rd);
   assign fw_b_raw = fwd_sel(ex_rs2, mem_reg_wr, mem_rd, wb_reg_wr, wb_rd);
   assign fw_p_raw = br_mode ? fwd_sel(id_rs1, mem_reg_wr, mem_rd, wb_reg_wr, wb_rd) : 2'b00;
   assign fw_q_raw = br_mode ? fwd_sel(id_rs2, mem_reg_wr, mem_rd, wb_reg_wr, wb_rd) : 2'b00;

   // Number of bubbles the ID instruction needs before its operands are reachable.
   always_comb begin
      hazard_n = 2'd0;
      if (br_mode) begin
         if (ex_hit && ex_mem_rd)        hazard_n = 2'd2;
         else if (ex_hit)                hazard_n = 2'd1;
         else if (mem_hit && mem_mem_rd) hazard_n = 2'd1;
      end else if (ex_hit && ex_mem_rd) begin
         hazard_n = 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_RUN;
      else        state_q <= state_d;
   end

   // A redirect discards the ID instruction, so it overrides any stall.
   always_comb begin
      state_d   = state_q;
      stall_raw = 1'b0;
      if (br_flush) begin
         state_d = S_RUN;
      end else begin
         case (state_q)
            S_RUN: begin
               if (hazard_n != 2'd0) begin
                  stall_raw = 1'b1;
                  if (hazard_n == 2'd2) state_d = S_HOLD;
               end
            end
            S_HOLD: begin
               stall_raw = 1'b1;
               state_d   = S_RUN;
            end
            default: state_d = S_RUN;
         endcase
      end
   end

   // Outputs are forced low while reset is asserted.
   assign fw_a     = rst_n ? fw_a_raw : 2'b00;
   assign fw_b     = rst_n ? fw_b_raw : 2'b00;
   assign fw_p     = rst_n ? fw_p_raw : 2'b00;
   assign fw_q     = rst_n ? fw_q_raw : 2'b00;
   assign stall    = rst_n && stall_raw;
   assign flush_ex = rst_n && stall_raw;

`ifdef HAZ_STATS_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             hazard_start;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] hazard_events_q, hazard_events_d;

   assign hazard_start = (state_q == S_RUN) && !br_flush && (hazard_n != 2'd0);

   always_comb begin
      stall_cycles_d  = stall_cycles_q;
      hazard_events_d = hazard_events_q;
      if (stall_raw && (stall_cycles_q != CNT_MAX))
         stall_cycles_d = stall_cycles_q + CNT_ONE;
      if (hazard_start && (hazard_events_q != CNT_MAX))
         hazard_events_d = hazard_events_q + CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_q  <= '0;
         hazard_events_q <= '0;
      end else begin
         stall_cycles_q  <= stall_cycles_d;
         hazard_events_q <= hazard_events_d;
      end
   end

   assign stall_cycles  = stall_cycles_q;
   assign hazard_events = hazard_events_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - directed self-checking bench for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;

   logic       clk;
   logic       rst_n;
   logic [6:0] id_opcode;
   logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic       ex_reg_wr, ex_mem_rd, mem_reg_wr, mem_mem_rd, wb_reg_wr, br_flush;

   logic [1:0] a1_fw_a, a1_fw_b, a1_fw_p, a1_fw_q;
   logic       a1_stall, a1_flush_ex;
   logic [1:0] a0_fw_a, a0_fw_b, a0_fw_p, a0_fw_q;
   logic       a0_stall, a0_flush_ex;
`ifdef HAZ_STATS_EN
   logic [1:0] a1_sc, a1_he, a0_sc, a0_he;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   fwd_hazard_ctrl #(.REG_AW(5), .BR_IN_ID(1'b1), .CNT_W(2)) u_id (
      .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd),
      .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr), .mem_mem_rd(mem_mem_rd),
      .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr), .br_flush(br_flush),
      .fw_a(a1_fw_a), .fw_b(a1_fw_b), .fw_p(a1_fw_p), .fw_q(a1_fw_q),
      .stall(a1_stall), .flush_ex(a1_flush_ex)
`ifdef HAZ_STATS_EN
      , .stall_cycles(a1_sc), .hazard_events(a1_he)
`endif
   );

   fwd_hazard_ctrl #(.REG_AW(5), .BR_IN_ID(1'b0), .CNT_W(2)) u_ex (
      .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd),
      .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr), .mem_mem_rd(mem_mem_rd),
      .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr), .br_flush(br_flush),
      .fw_a(a0_fw_a), .fw_b(a0_fw_b), .fw_p(a0_fw_p), .fw_q(a0_fw_q),
      .stall(a0_stall), .flush_ex(a0_flush_ex)
`ifdef HAZ_STATS_EN
      , .stall_cycles(a0_sc), .hazard_events(a0_he)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clr();
      id_opcode = 7'b0010011;
      id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0;
      ex_rd = '0; mem_rd = '0; wb_rd = '0;
      ex_reg_wr = 1'b0; ex_mem_rd = 1'b0; mem_reg_wr = 1'b0;
      mem_mem_rd = 1'b0; wb_reg_wr = 1'b0; br_flush = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clr();
      ex_rs1 = 5'd5; mem_rd = 5'd5; mem_reg_wr = 1'b1;
      id_opcode = 7'b0110011; id_rs2 = 5'd7; ex_rd = 5'd7; ex_reg_wr = 1'b1; ex_mem_rd = 1'b1;
      #1;
      n_chk++; if (a1_fw_a !== 2'b00) $display("FAIL reset_fw_a got %b want 00", a1_fw_a); else n_pass++;
      n_chk++; if (a1_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", a1_stall); else n_pass++;
      n_chk++; if (a1_flush_ex !== 1'b0) $display("FAIL reset_flush_ex got %b want 0", a1_flush_ex); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      clr();
      #1;
      n_chk++; if (a1_stall !== 1'b0) $display("FAIL post_reset_stall got %b want 0", a1_stall); else n_pass++;
   endtask

   task automatic test_forward();
      @(negedge clk);
      clr();
      ex_rs1 = 5'd5; mem_rd = 5'd5; mem_reg_wr = 1'b1; wb_rd = 5'd5; wb_reg_wr = 1'b1;
      #1;
      n_chk++; if (a1_fw_a !== 2'b01) $display("FAIL fw_a_exmem got %b want 01", a1_fw_a); else n_pass++;
      mem_reg_wr = 1'b0;
      #1;
      n_chk++; if (a1_fw_a !== 2'b10) $display("FAIL fw_a_memwb got %b want 10", a1_fw_a); else n_pass++;
      mem_reg_wr = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
      #1;
      n_chk++; if (a1_fw_a !== 2'b00) $display("FAIL fw_a_rd0 got %b want 00", a1_fw_a); else n_pass++;
      ex_rs2 = 5'd9; wb_rd = 5'd9; mem_rd = 5'd8;
      #1;
      n_chk++; if (a0_fw_b !== 2'b10) $display("FAIL fw_b_memwb got %b want 10", a0_fw_b); else n_pass++;
   endtask

   task automatic test_load_use();
      @(negedge clk);
      clr();
      id_opcode = 7'b0110011; id_rs2 = 5'd7;
      ex_rd = 5'd7; ex_reg_wr = 1'b1; ex_mem_rd = 1'b1;
      #1;
      n_chk++; if (a1_stall !== 1'b1) $display("FAIL lu_stall got %b want 1", a1_stall); else n_pass++;
      n_chk++; if (a1_flush_ex !== 1'b1) $display("FAIL lu_flush_ex got %b want 1", a1_flush_ex); else n_pass++;
      n_chk++; if (a0_stall !== 1'b1) $display("FAIL lu_stall_exmode got %b want 1", a0_stall); else n_pass++;
      @(negedge clk);
      ex_reg_wr = 1'b0; ex_mem_rd = 1'b0; ex_rd = 5'd0;
      mem_rd = 5'd7; mem_reg_wr = 1'b1; mem_mem_rd = 1'b1;
      #1;
      n_chk++; if (a1_stall !== 1'b0) $display("FAIL lu_one_cycle got %b want 0", a1_stall); else n_pass++;
      @(negedge clk);
      clr();
      id_opcode = 7'b0010011; id_rs2 = 5'd7;
      ex_rd = 5'd7; ex_reg_wr = 1'b1; ex_mem_rd = 1'b1;
      #1;
      n_chk++; if (a1_stall !== 1'b0) $display("FAIL lu_rs2_unused got %b want 0", a1_stall); else n_pass++;
   endtask

   task automatic test_branch_load();
      @(negedge clk);
      clr();
      id_opcode = 7'b1100011; id_rs1 = 5'd3;
      ex_rd = 5'd3; ex_reg_wr = 1'b1; ex_mem_rd = 1'b1;
      #1;
      n_chk++; if (a1_stall !== 1'b1) $display("FAIL bl_stall1 got %b want 1", a1_stall); else n_pass++;
      n_chk++; if (a0_stall !== 1'b1) $display("FAIL bl_exmode_stall1 got %b want 1", a0_stall); else n_pass++;
      @(negedge clk);
      ex_rd = 5'd0; ex_reg_wr = 1'b0; ex_mem_rd = 1'b0;
      mem_rd = 5'd3; mem_reg_wr = 1'b1; mem_mem_rd = 1'b1;
      #1;
      n_chk++; if (a1_stall !== 1'b1) $display("FAIL bl_stall2 got %b want 1", a1_stall); else n_pass++;
      n_chk++; if (a0_stall !== 1'b0) $display("FAIL bl_exmode_stall2 got %b want 0", a0_stall); else n_pass++;
      @(negedge clk);
      mem_rd = 5'd0; mem_reg_wr = 1'b0; mem_mem_rd = 1'b0;
      wb_rd = 5'd3; wb_reg_wr = 1'b1;
      #1;
      n_chk++; if (a1_stall !== 1'b0) $display("FAIL bl_stall3 got %b want 0", a1_stall); else n_pass++;
      n_chk++; if (a1_fw_p !== 2'b10) $display("FAIL bl_fw_p got %b want 10", a1_fw_p); else n_pass++;
      n_chk++; if (a0_fw_p !== 2'b00) $display("FAIL bl_exmode_fw_p got %b want 00", a0_fw_p); else n_pass++;
   endtask

   task automatic test_branch_alu();
      @(negedge clk);
      clr();
      id_opcode = 7'b1100011; id_rs2 = 5'd4;
      ex_rd = 5'd4; ex_reg_wr = 1'b1;
      #1;
      n_chk++; if (a1_stall !== 1'b1) $display("FAIL ba_stall got %b want 1", a1_stall); else n_pass++;
      n_chk++; if (a0_stall !== 1'b0) $display("FAIL ba_exmode_stall got %b want 0", a0_stall); else n_pass++;
      @(negedge clk);
      ex_rd = 5'd0; ex_reg_wr = 1'b0;
      mem_rd = 5'd4; mem_reg_wr = 1'b1;
      #1;
      n_chk++; if (a1_stall !== 1'b0) $display("FAIL ba_no_hold got %b want 0", a1_stall); else n_pass++;
      n_chk++; if (a1_fw_q !== 2'b01) $display("FAIL ba_fw_q got %b want 01", a1_fw_q); else n_pass++;
      n_chk++; if (a0_fw_q !== 2'b00) $display("FAIL ba_exmode_fw_q got %b want 00", a0_fw_q); else n_pass++;
   endtask

   task automatic test_flush();
      @(negedge clk);
      clr();
      id_opcode = 7'b1100011; id_rs1 = 5'd3;
      ex_rd = 5'd3; ex_reg_wr = 1'b1; ex_mem_rd = 1'b1;
      br_flush = 1'b1;
      #1;
      n_chk++; if (a1_stall !== 1'b0) $display("FAIL fl_stall got %b want 0", a1_stall); else n_pass++;
      n_chk++; if (a1_flush_ex !== 1'b0) $display("FAIL fl_flush_ex got %b want 0", a1_flush_ex); else n_pass++;
      @(negedge clk);
      clr();
      #1;
      n_chk++; if (a1_stall !== 1'b0) $display("FAIL fl_state_run got %b want 0", a1_stall); else n_pass++;
   endtask

   task automatic test_reset_hold();
      @(negedge clk);
      clr();
      id_opcode = 7'b1100011; id_rs1 = 5'd3;
      ex_rd = 5'd3; ex_reg_wr = 1'b1; ex_mem_rd = 1'b1;
      @(negedge clk);
      clr();
      #1;
      n_chk++; if (a1_stall !== 1'b1) $display("FAIL rh_hold_stall got %b want 1", a1_stall); else n_pass++;
      #1 rst_n = 1'b0;
      #1;
      n_chk++; if (a1_stall !== 1'b0) $display("FAIL rh_reset_stall got %b want 0", a1_stall); else n_pass++;
      n_chk++; if (a1_flush_ex !== 1'b0) $display("FAIL rh_reset_flush got %b want 0", a1_flush_ex); else n_pass++;
      #1 rst_n = 1'b1;
      @(negedge clk);
      #1;
      n_chk++; if (a1_stall !== 1'b0) $display("FAIL rh_state_run got %b want 0", a1_stall); else n_pass++;
   endtask

`ifdef HAZ_STATS_EN
   task automatic test_stats();
      @(negedge clk);
      clr();
      rst_n = 1'b0;
      #1;
      n_chk++; if (a1_sc !== 2'd0) $display("FAIL st_reset_sc got %0d want 0", a1_sc); else n_pass++;
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         id_opcode = 7'b0110011; id_rs2 = 5'd7;
         ex_rd = 5'd7; ex_reg_wr = 1'b1; ex_mem_rd = 1'b1;
      end
      @(negedge clk);
      br_flush = 1'b1;
      #1;
      n_chk++; if (a1_sc !== 2'd2) $display("FAIL st_sc2 got %0d want 2", a1_sc); else n_pass++;
      n_chk++; if (a1_he !== 2'd2) $display("FAIL st_he2 got %0d want 2", a1_he); else n_pass++;
      @(negedge clk);
      br_flush = 1'b0;
      #1;
      n_chk++; if (a1_he !== 2'd2) $display("FAIL st_flush_he got %0d want 2", a1_he); else n_pass++;
      n_chk++; if (a1_sc !== 2'd2) $display("FAIL st_flush_sc got %0d want 2", a1_sc); else n_pass++;
      for (int i = 0; i < 3; i++) @(negedge clk);
      #1;
      n_chk++; if (a1_sc !== 2'd3) $display("FAIL st_sc_sat got %0d want 3", a1_sc); else n_pass++;
      n_chk++; if (a1_he !== 2'd3) $display("FAIL st_he_sat got %0d want 3", a1_he); else n_pass++;
      clr();
   endtask
`endif

   initial begin
      test_reset();
      test_forward();
      test_load_use();
      test_branch_load();
      test_branch_alu();
      test_flush();
      test_reset_hold();
`ifdef HAZ_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
